exprom_ctrl: RTL and testbench
==============================

Name: exprom_ctrl

Overview:
- Access controller and arbiter for the PCI expansion-ROM store: four byte-lane 512x8 block RAMs forming a 512x32 image.
- Shares the RAMs between three requesters: the PCI target read path (dword reads), the management write port (byte patches) and an internal checksum-scan engine.
- The scan engine verifies that the image byte sum is 0 mod 256.
- Sits between the PCI target FSM and the four lane RAMs. Drives their shared address, data-in, per-lane enables and per-lane write enables.

Parameters:
- ADDR_W, 9, dword address width (RAM depth = 2^ADDR_W).
- ROM_WORDS, 512, number of dwords covered by a checksum scan (1..2^ADDR_W).
- MAX_WAIT, 8, number of cycles a pending write may be blocked by reads before it is forced through.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rd_req  in  1  PCI read request; held until rd_gnt
- rd_addr  in  ADDR_W  dword address
- rd_gnt  out  1  one-cycle pulse: read issued this cycle
- rd_valid  out  1  one-cycle pulse: rd_data valid
- rd_data  out  32  read data; lane i = bits 8i+7:8i
- wr_req  in  1  management byte-write request; held until wr_gnt
- wr_addr  in  ADDR_W+2  byte address; [1:0] = lane, [ADDR_W+1:2] = dword
- wr_data  in  8  write byte
- wr_prot  in  1  write-protect
- wr_gnt  out  1  one-cycle pulse: write slot consumed
- wr_err  out  1  one-cycle pulse with wr_gnt when the write was suppressed by wr_prot
- scan_start  in  1  start checksum scan (pulse)
- scan_busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse: scan complete
- scan_sum  out  8  byte sum mod 256
- scan_ok  out  1  scan_sum == 0 and no stale condition
- scan_stale  out  1  a write was accepted during the last scan
- rom_addr  out  ADDR_W  shared RAM address
- rom_din  out  8  shared RAM write data
- rom_en  out  4  per-lane enable
- rom_we  out  4  per-lane write enable
- rom_dout  in  32  concatenated RAM outputs, lane 3 in the MSB

Behaviour:
- RAM model: synchronous read. A read issued with rom_en at edge N presents data on rom_dout after edge N; the output holds until the next enabled edge.
- Slot rule: at most one operation per cycle. rom_en and rom_we are 0 in idle cycles.
- Priority, evaluated each cycle:
  1. Write, if wr_req and wait_cnt >= MAX_WAIT.
  2. Otherwise read, if rd_req.
  3. Otherwise write, if wr_req.
  4. Otherwise the next scan word, if scan_busy.
- wait_cnt: counts cycles with wr_req high and no wr_gnt, saturating at MAX_WAIT. It clears on wr_gnt.
- Read:
  - Grant cycle: rom_addr=rd_addr, rom_en=4'hF, rom_we=0, rd_gnt=1.
  - Next cycle: rd_valid=1, rd_data=rom_dout (combinational pass-through, not registered).
  - Latency from grant to valid is 1 cycle. Back-to-back grants give back-to-back valids.
- Write:
  - Grant cycle: rom_addr=wr_addr[ADDR_W+1:2], rom_din=wr_data, rom_en=rom_we=one-hot(wr_addr[1:0]), wr_gnt=1.
  - If wr_prot: rom_en=rom_we=0, wr_gnt=1, wr_err=1; the write is still considered consumed.
- Scan FSM states:
  - IDLE -> RUN when scan_start is seen in IDLE: clear scan_sum, clear scan_stale, set ptr=0, set scan_busy.
  - RUN: when a scan slot is granted, issue rom_addr=ptr with rom_en=4'hF and increment ptr. In the following cycle add the four rom_dout bytes into scan_sum, mod 256.
  - RUN -> DONE when the final word (ptr = ROM_WORDS-1) has been accumulated.
  - DONE (one cycle): scan_done=1, scan_busy=0, scan_ok updated; then -> IDLE.
  - scan_start while RUN/DONE: ignored.
- Scan/write interaction: any non-suppressed write accepted while scan_busy sets scan_stale. scan_ok = (scan_sum==0) && !scan_stale.
- Stall: scan issue pauses indefinitely under read/write traffic. Accumulation always happens in the cycle immediately after a scan issue, regardless of what is issued that cycle.
- Pointer: ptr is ADDR_W bits and never wraps past ROM_WORDS-1.
- Simultaneous rd_req and wr_req with wait_cnt < MAX_WAIT: read wins and wait_cnt increments.
- Reset values: all outputs 0 (including scan_sum, scan_ok, scan_stale, rom_*). FSM -> IDLE, wait_cnt=0.
- Reset mid-operation: a scan in progress aborts with no scan_done. No rom_we in the reset cycle. A rd_valid owed by a read granted in the cycle before reset is dropped.

Test Plan:
- Read path: preload lanes of dword 0 with 0x55,0xAA,0x04,0xEB (lane3..0); rd_req addr 0 -> rd_gnt at cycle T, rd_valid at T+1, rd_data=0x55AA04EB; 4 back-to-back reads -> 4 consecutive valids with no gaps.
- Byte write: wr_addr=0x006 (dword 1, lane 2), data 0x3C, wr_prot=0 -> rom_we=4'b0100, rom_addr=1; a subsequent read of dword 1 returns bits 23:16 = 0x3C. Repeat with wr_prot=1 -> wr_err pulse, rom_we=0, data unchanged.
- Starvation: rd_req held high continuously with wr_req asserted -> wr_gnt exactly MAX_WAIT=8 cycles after wr_req rises; no rd_gnt in that cycle; reads resume in the next cycle.
- Scan: image with ROM_WORDS=512 whose bytes sum to 0x00 -> scan_done after 513 idle cycles, scan_ok=1. Change one byte by +1 and rescan -> scan_sum=0x01, scan_ok=0.
- Scan under traffic: random rd_req at 50% duty during a scan -> reads unaffected, scan_sum is correct, scan_done is delayed. One unprotected write mid-scan -> scan_stale=1, scan_ok=0.
- Reset mid-scan at word 100 -> scan_busy=0, no scan_done, all rom_* outputs 0. A subsequent scan_start gives a full correct scan.

Source files
------------

// File: rtl/exprom_ctrl.sv
// exprom_ctrl: access controller and arbiter for the PCI expansion-ROM store.
// Four byte-lane 512x8 synchronous RAMs form one 32-bit image that is shared by
// three requesters. Only one of them gets the RAMs in any cycle.
//   - PCI target reads: full dwords, with one cycle from grant to data.
//   - Management writes: single-byte patches, optionally write-protected.
//   - Checksum-scan engine: sums every image byte mod 256.
// Arbitration order: a starved write first, then a read, then any write, then
// the next scan word.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_req/addr/gnt     read request handshake (request held until grant)
//   rd_valid/rd_data    read response, one cycle after rd_gnt
//   wr_req/addr/data    byte write request (wr_addr[1:0] selects the lane)
//   wr_prot/gnt/err     write protect, grant pulse, suppressed-write pulse
//   scan_*              checksum-scan control and result
//   rom_*               shared RAM address/data/enables; rom_dout from RAMs
module exprom_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int ROM_WORDS = 512,
  parameter int MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W+1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              wr_prot,
  output logic              wr_gnt,
  output logic              wr_err,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic              scan_done,
  output logic [7:0]        scan_sum,
  output logic              scan_ok,
  output logic              scan_stale,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_din,
  output logic [3:0]        rom_en,
  output logic [3:0]        rom_we,
  input  logic [31:0]       rom_dout
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROM_WORDS - 1);
  localparam logic [WC_W-1:0]   WMAX = WC_W'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              issued_q, issued_d;  // final scan word already issued
  logic              acc_q;               // scan word arriving on rom_dout
  logic              last_q;              // ...and it is the final one
  logic [7:0]        sum_q, sum_d;
  logic              stale_q, stale_d;
  logic              ok_q, ok_d;
  logic              rdv_q;

  logic              force_wr, rd_g, wr_g, sc_g;
  logic [3:0]        lane_oh;
  logic [7:0]        word_sum;

  // Slot arbitration. Nothing is granted during reset, so no RAM write can
  // happen in the reset cycle.
  always_comb begin
    force_wr = wr_req && (wait_q >= WMAX);
    rd_g     = !rst && rd_req && !force_wr;
    wr_g     = !rst && wr_req && (force_wr || !rd_req);
    sc_g     = !rst && !rd_g && !wr_g && (state_q == S_RUN) && !issued_q;
  end

  // RAM port drive
  always_comb begin
    rom_addr = '0;
    rom_din  = '0;
    rom_en   = '0;
    rom_we   = '0;
    lane_oh  = 4'b0001 << wr_addr[1:0];
    if (rd_g) begin
      rom_addr = rd_addr;
      rom_en   = 4'hF;
    end else if (wr_g) begin
      rom_addr = wr_addr[ADDR_W+1:2];
      rom_din  = wr_data;
      rom_en   = wr_prot ? 4'h0 : lane_oh;
      rom_we   = wr_prot ? 4'h0 : lane_oh;
    end else if (sc_g) begin
      rom_addr = ptr_q;
      rom_en   = 4'hF;
    end
  end

  // Write starvation counter
  always_comb begin
    wait_d = wait_q;
    if (wr_g)                         wait_d = '0;
    else if (wr_req && wait_q < WMAX) wait_d = wait_q + 1'b1;
  end

  // Scan engine
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    issued_d = issued_q;
    sum_d    = sum_q;
    stale_d  = stale_q;
    ok_d     = ok_q;
    word_sum = rom_dout[7:0] + rom_dout[15:8] + rom_dout[23:16] + rom_dout[31:24];
    case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          state_d  = S_RUN;
          ptr_d    = '0;
          issued_d = 1'b0;
          sum_d    = '0;
          stale_d  = 1'b0;
        end
      end
      S_RUN: begin
        // ptr parks on the final word rather than wrapping
        if (sc_g) begin
          if (ptr_q == LAST) issued_d = 1'b1;
          else               ptr_d    = ptr_q + 1'b1;
        end
        // accumulate unconditionally one cycle after issue; RAM output is
        // only disturbed by the next enabled edge, which happens after this
        if (acc_q) sum_d = sum_q + word_sum;
        if (wr_g && !wr_prot) stale_d = 1'b1;
        if (acc_q && last_q) begin
          state_d = S_DONE;
          ok_d    = (sum_d == 8'd0) && !stale_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      ptr_q    <= '0;
      issued_q <= 1'b0;
      acc_q    <= 1'b0;
      last_q   <= 1'b0;
      sum_q    <= '0;
      stale_q  <= 1'b0;
      ok_q     <= 1'b0;
      rdv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      ptr_q    <= ptr_d;
      issued_q <= issued_d;
      acc_q    <= sc_g;
      last_q   <= sc_g && (ptr_q == LAST);
      sum_q    <= sum_d;
      stale_q  <= stale_d;
      ok_q     <= ok_d;
      rdv_q    <= rd_g;
    end
  end

  // Outputs are forced low while reset is asserted; this also drops a
  // response owed by a read granted just before reset.
  always_comb begin
    rd_gnt     = rd_g;
    wr_gnt     = wr_g;
    wr_err     = wr_g && wr_prot;
    rd_valid   = rdv_q && !rst;
    rd_data    = rd_valid ? rom_dout : 32'd0;
    scan_busy  = !rst && (state_q == S_RUN);
    scan_done  = !rst && (state_q == S_DONE);
    scan_sum   = rst ? 8'd0 : sum_q;
    scan_ok    = !rst && ok_q;
    scan_stale = !rst && stale_q;
  end

endmodule

// File: tb/tb_exprom_ctrl.sv
module tb_exprom_ctrl;
  localparam int AW = 9;
  localparam int RW = 512;
  localparam int MW = 8;
  localparam int NB = 4 << AW;

  logic clk = 0;
  always #5 clk = ~clk;

  logic          rst = 1;
  logic          rd_req = 0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt, rd_valid;
  logic [31:0]   rd_data;
  logic          wr_req = 0;
  logic [AW+1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          wr_prot = 0;
  logic          wr_gnt, wr_err;
  logic          scan_start = 0;
  logic          scan_busy, scan_done, scan_ok, scan_stale;
  logic [7:0]    scan_sum;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_din;
  logic [3:0]    rom_en, rom_we;
  logic [31:0]   rom_dout;

  exprom_ctrl #(.ADDR_W(AW), .ROM_WORDS(RW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_prot(wr_prot),
    .wr_gnt(wr_gnt), .wr_err(wr_err),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
    .scan_sum(scan_sum), .scan_ok(scan_ok), .scan_stale(scan_stale),
    .rom_addr(rom_addr), .rom_din(rom_din), .rom_en(rom_en), .rom_we(rom_we),
    .rom_dout(rom_dout)
  );

  // lane RAMs: synchronous read, output held until the next enabled edge
  logic [7:0] mem [4][1<<AW];
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (rom_en[i]) begin
        if (rom_we[i]) mem[i][rom_addr] <= rom_din;
        else           rom_dout[8*i +: 8] <= mem[i][rom_addr];
      end

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: byte image, expected read responses, scan bookkeeping
  logic [7:0] gold [NB];
  typedef struct { logic [31:0] d; int c; } rexp_t;
  rexp_t rq[$];
  int    cyc = 0;
  bit    act_m = 0, stale_m = 0;
  int    start_c = 0, done_cnt = 0, done_lat = 0;
  bit    rd_gnt_s = 0, wr_gnt_s = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] gdw(input logic [AW-1:0] a);
    int b;
    b = int'(a) * 4;
    return {gold[b+3], gold[b+2], gold[b+1], gold[b]};
  endfunction

  function automatic logic [7:0] gsum();
    logic [7:0] s;
    s = 8'd0;
    for (int b = 0; b < RW*4; b++) s = s + gold[b];
    return s;
  endfunction

  always @(negedge clk) begin
    rd_gnt_s = rd_gnt;
    wr_gnt_s = wr_gnt;
    if (rst) begin
      chk("rst_we", rom_we, 0);
      chk("rst_en", rom_en, 0);
      chk("rst_rdv", rd_valid, 0);
      chk("rst_busy", scan_busy, 0);
      chk("rst_done", scan_done, 0);
      rq.delete();
      act_m = 0;
    end else begin
      chk("one_op", rd_gnt & wr_gnt, 0);
      if (rd_gnt) begin
        chk("rd_en", rom_en, 4'hF);
        chk("rd_we", rom_we, 0);
        chk("rd_addr", rom_addr, rd_addr);
        rq.push_back('{gdw(rd_addr), cyc});
      end
      if (rd_valid) begin
        if (rq.size() == 0) chk("rdv_spurious", 1, 0);
        else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rd_data", rd_data, e.d);
          chk("rd_lat", cyc - e.c, 1);
        end
      end
      if (!act_m) begin
        chk("done_spurious", scan_done, 0);
        chk("busy_idle", scan_busy, 0);
      end else if (scan_done) begin
        chk("busy_done", scan_busy, 0);
        chk("scan_stale", scan_stale, stale_m);
        if (!stale_m) chk("scan_sum", scan_sum, gsum());
        chk("scan_ok", scan_ok, !stale_m && (gsum() == 8'd0));
        done_lat = cyc - start_c;
        done_cnt++;
        act_m = 0;
      end
      if (wr_gnt) begin
        logic [3:0] oh;
        oh = wr_prot ? 4'h0 : (4'b0001 << wr_addr[1:0]);
        chk("wr_we", rom_we, oh);
        chk("wr_en", rom_en, oh);
        chk("wr_err", wr_err, wr_prot);
        if (!wr_prot) begin
          chk("wr_addr", rom_addr, wr_addr[AW+1:2]);
          chk("wr_din", rom_din, wr_data);
          gold[wr_addr] = wr_data;
          if (act_m) stale_m = 1;
        end
      end else chk("wr_err_idle", wr_err, 0);
      if (scan_start && !act_m) begin
        act_m = 1;
        stale_m = 0;
        start_c = cyc;
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    rd_req = 0; wr_req = 0; scan_start = 0;
  endtask

  task automatic wr1(input int a, input logic [7:0] d, input bit p);
    int k;
    @(posedge clk); #1;
    wr_req = 1; wr_addr = (AW+2)'(a); wr_data = d; wr_prot = p;
    k = 0;
    @(negedge clk);
    while (!wr_gnt && k < 100) begin @(negedge clk); k++; end
    if (!wr_gnt) chk("tmo_wr", 0, 1);
  endtask

  task automatic rd1(input int a);
    int k;
    @(posedge clk); #1;
    rd_req = 1; rd_addr = AW'(a);
    k = 0;
    @(negedge clk);
    while (!rd_gnt && k < 100) begin @(negedge clk); k++; end
    if (!rd_gnt) chk("tmo_rd", 0, 1);
  endtask

  // one cycle of handshake-respecting random traffic
  task automatic step(input int rd_pct, input int wr_pct, input int prot_pct);
    logic [31:0] r;
    @(posedge clk); #1;
    if (rd_req && rd_gnt_s) rd_req = 0;
    if (wr_req && wr_gnt_s) wr_req = 0;
    if (!rd_req && $urandom_range(99) < rd_pct) begin
      r = $urandom; rd_req = 1; rd_addr = r[AW-1:0];
    end
    if (!wr_req && $urandom_range(99) < wr_pct) begin
      r = $urandom; wr_req = 1; wr_addr = r[AW+1:0]; wr_data = r[31:24];
      wr_prot = ($urandom_range(99) < prot_pct);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((rd_req || wr_req) && k < 200) begin step(0, 0, 0); k++; end
    if (rd_req || wr_req) chk("tmo_drain", 0, 1);
    idle();
  endtask

  task automatic start_scan();
    @(posedge clk); #1; scan_start = 1;
    @(posedge clk); #1; scan_start = 0;
  endtask

  // waits for the next scan_done with optional 50% read traffic
  task automatic wait_done(input int n0, input bit traffic);
    int k;
    k = 0;
    while (done_cnt == n0 && k < 5000) begin
      if (traffic) step(50, 0, 0);
      else begin @(posedge clk); #1; end
      k++;
    end
    if (done_cnt == n0) chk("tmo_scan", 0, 1);
  endtask

  initial begin
    int n, k;
    logic [7:0] s, b;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("r_rd_gnt", rd_gnt, 0);   chk("r_rd_valid", rd_valid, 0);
    chk("r_rd_data", rd_data, 0); chk("r_wr_gnt", wr_gnt, 0);
    chk("r_wr_err", wr_err, 0);   chk("r_busy", scan_busy, 0);
    chk("r_done", scan_done, 0);  chk("r_sum", scan_sum, 0);
    chk("r_ok", scan_ok, 0);      chk("r_stale", scan_stale, 0);
    chk("r_addr", rom_addr, 0);   chk("r_din", rom_din, 0);
    chk("r_en", rom_en, 0);       chk("r_we", rom_we, 0);

    // preload: dword 0 = 55AA04EB, rest random, image byte sum = 0
    wr1(0, 8'hEB, 0); wr1(1, 8'h04, 0); wr1(2, 8'hAA, 0); wr1(3, 8'h55, 0);
    s = 8'hEE;
    for (int i = 4; i < NB - 1; i++) begin
      b = 8'($urandom); s = s + b; wr1(i, b, 0);
    end
    wr1(NB - 1, 8'd0 - s, 0);
    idle();

    // read path
    rd1(0); idle();
    @(negedge clk);
    chk("rd0_valid", rd_valid, 1);
    chk("rd0_data", rd_data, 32'h55AA04EB);
    rd1(1); rd1(2); rd1(3); rd1(4); idle();
    repeat (3) idle();

    // idle scan of a zero-sum image
    n = done_cnt; start_scan(); wait_done(n, 0);
    chk("scan0_lat", done_lat, RW + 2);
    chk("scan0_ok", scan_ok, 1);
    chk("scan0_sum", scan_sum, 0);

    // bump one byte, rescan
    wr1(10, gold[10] + 8'd1, 0); idle();
    n = done_cnt; start_scan(); wait_done(n, 0);
    chk("scan1_sum", scan_sum, 8'h01);
    chk("scan1_ok", scan_ok, 0);

    // byte write to dword 1 lane 2, then protected attempt
    wr1(6, 8'h3C, 0);
    chk("bw_we", rom_we, 4'b0100);
    chk("bw_addr", rom_addr, 1);
    idle();
    rd1(1); idle(); @(negedge clk);
    chk("bw_rd", rd_data[23:16], 8'h3C);
    wr1(6, 8'h99, 1);
    chk("bp_err", wr_err, 1);
    chk("bp_we", rom_we, 0);
    idle();
    rd1(1); idle(); @(negedge clk);
    chk("bp_rd", rd_data[23:16], 8'h3C);

    // write starvation under continuous reads
    @(posedge clk); #1; rd_req = 1; rd_addr = 5;
    repeat (3) @(posedge clk);
    #1; wr_req = 1; wr_addr = 20; wr_data = 8'h77; wr_prot = 0;
    k = 0;
    @(negedge clk);
    while (!wr_gnt && k < 40) begin @(negedge clk); k++; end
    chk("starve_lat", k, MW);
    chk("starve_nord", rd_gnt, 0);
    @(posedge clk); #1; wr_req = 0;
    @(negedge clk);
    chk("starve_resume", rd_gnt, 1);
    idle();

    // scan with 50% read traffic
    n = done_cnt; start_scan(); wait_done(n, 1);
    chk("scan_delayed", done_lat > RW + 2, 1);
    drain();

    // scan with one unprotected write mid-scan
    n = done_cnt; start_scan();
    repeat (100) step(50, 0, 0);
    wr1(300, 8'h5A, 0);
    @(posedge clk); #1; wr_req = 0;
    wait_done(n, 1);
    chk("stale_flag", scan_stale, 1);
    chk("stale_ok", scan_ok, 0);
    drain();

    // reset mid-scan, with a read granted in the cycle before reset
    start_scan();
    repeat (100) idle();
    @(posedge clk); #1; rd_req = 1; rd_addr = 7;
    @(posedge clk); #1; rd_req = 0; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("ra_busy", scan_busy, 0); chk("ra_sum", scan_sum, 0);
    chk("ra_ok", scan_ok, 0);     chk("ra_stale", scan_stale, 0);
    chk("ra_en", rom_en, 0);      chk("ra_we", rom_we, 0);
    chk("ra_addr", rom_addr, 0);  chk("ra_rdv", rd_valid, 0);
    n = done_cnt;
    repeat (600) idle();
    chk("ra_nodone", done_cnt, n);
    start_scan(); wait_done(n, 0);
    chk("ra_rescan_lat", done_lat, RW + 2);

    // mixed random traffic
    repeat (300) step(40, 30, 30);
    drain();
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
